audio_receiver: RTL and testbench
=================================

AUDIO_RECEIVER -- requirements
Module: audio_receiver

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: 100 MHz system clock, the only clock.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-low (asserted at 0).
REQ-003 The block SHALL have the port adc_sdout, input, 1 bit: serial audio data from the codec ADC, asynchronous to clk.
REQ-004 The block SHALL have the port adc_mclk, output, 1 bit: codec master clock.
REQ-005 The block SHALL have the port adc_lrck, output, 1 bit: word-select clock; low = left, high = right.
REQ-006 The block SHALL have the port adc_sck, output, 1 bit: serial clock, constant 1 (codec internal serial clock mode).
REQ-007 The block SHALL have the port sample_left, output, 16 bits: last accepted left sample, two's complement.
REQ-008 The block SHALL have the port sample_right, output, 16 bits: last accepted right sample, two's complement.
REQ-009 The block SHALL have the port out_valid, output, 1 bit: sample pair available.
REQ-010 The block SHALL have the port out_ready, input, 1 bit: consumer accepts the pair.
REQ-011 The block SHALL have the port overrun, output, 1 bit: sticky flag, set when a frame is dropped.
REQ-012 The block SHALL have the port overrun_clr, input, 1 bit: clears overrun.
REQ-013 The block SHALL have the port peak_level, output, 16 bits: peak magnitude (see Configuration).
REQ-014 The block SHALL have the port peak_clr, input, 1 bit: restarts the peak measurement.

Function
REQ-015 A free-running 9-bit counter cnt SHALL increment every clk and wrap from 511 to 0.
- adc_mclk = cnt[1] (25 MHz).
- adc_lrck = cnt[8] (195.3125 kHz frame).
- Bit slot = cnt[8:4], giving 32 slots of 16 clk each.
REQ-016 adc_sdout SHALL pass through a 2-flop synchronizer before any use.
REQ-017 The synchronized bit SHALL be sampled once per slot, when cnt[3:0] == 9, into the slot given by cnt[8:4].
REQ-018 Slot mapping SHALL be:
- slot 0: right[0] of the previous frame.
- slots 1..16: left[15..0].
- slots 17..31: right[15..1].
REQ-019 A frame SHALL be complete at the slot-0 sample (cnt == 9).
REQ-020 On frame completion with out_valid == 0, the assembled pair SHALL be loaded into sample_left/sample_right and out_valid SHALL be set at the next edge (cnt == 10).
REQ-021 The pair SHALL be accepted when out_valid && out_ready; out_valid SHALL deassert at the next edge, and the sample outputs SHALL hold their values.
REQ-022 Simultaneous acceptance and frame completion SHALL load the new pair and keep out_valid at 1.
REQ-023 Frame completion while out_valid && !out_ready SHALL drop the new pair, keep the old outputs, and set overrun.
REQ-024 overrun SHALL hold until overrun_clr; a set event in the same cycle as overrun_clr SHALL win.
REQ-025 The first frame completion after reset SHALL be discarded without setting overrun (partial frame).
REQ-026 The internal shift state SHALL NOT depend on the handshake; reception continues during stalls.

Reset
REQ-027 While rst == 0, the block SHALL hold:
- cnt = 0 and synchronizer flops = 0.
- sample_left = sample_right = 0.
- out_valid = 0, overrun = 0, peak_level = 0.
- The primed flag clear.
REQ-028 Reset asserted mid-frame SHALL abandon the partial frame; after release, REQ-025 applies again.

Configuration
REQ-029 With macro PEAK_METER_EN defined, on each accepted load (REQ-020/022) the block SHALL set peak_level = max(peak_level, |left|, |right|).
- |x| is saturating: |-32768| = 32767.
- peak_clr SHALL set peak_level = 0 in the same edge; a simultaneous load SHALL then set peak_level = max(|left|, |right|) of that pair.
REQ-030 Without PEAK_METER_EN, peak_level SHALL be constant 0 and peak_clr SHALL be ignored; no peak logic SHALL be synthesized.

Verification
REQ-031 Reset release, then serialize L=16'h1234 / R=16'hABCD on adc_sdout per REQ-018, out_ready=1 -> second completed frame gives sample_left=16'h1234, sample_right=16'hABCD, out_valid high from cnt==10; the first frame is discarded.
REQ-032 out_ready=0 for 3 frames with L=1, 2, 3 -> outputs hold pair 1 and overrun=1; after overrun_clr pulse, overrun=0.
REQ-033 out_ready=1 at exactly the completion edge -> out_valid stays 1 and the new pair is loaded with no overrun.
REQ-034 PEAK_METER_EN, frames L=16'h8000, R=16'h0100 then L=16'h0200, R=16'hFF00 -> peak_level=16'h7FFF; peak_clr then next frame L=16'h0010, R=16'hFFF0 -> peak_level=16'h0010.
REQ-035 rst pulsed low at cnt==200 -> all outputs 0 immediately, cnt restarts at 0, and the next completion is discarded.
REQ-036 Without PEAK_METER_EN, any traffic plus peak_clr -> peak_level==0 throughout.

Source files
------------

// File: rtl/audio_receiver.sv
// audio_receiver: serial codec ADC front end.
// Generates the codec clocks from a free-running 9-bit counter, synchronizes
// and deserializes adc_sdout into 16-bit left/right pairs, and presents each
// complete frame through a valid/ready handshake with a sticky overrun flag.
// Optional feature macro: PEAK_METER_EN (peak magnitude meter on peak_level).
//
// Ports:
//   clk, rst (async, active-low)   100 MHz clock and reset
//   adc_sdout                      serial data from codec (async to clk)
//   adc_mclk / adc_lrck / adc_sck  codec master, word-select and serial clocks
//   sample_left / sample_right     last accepted pair, two's complement
//   out_valid / out_ready          pair handshake
//   overrun / overrun_clr          sticky dropped-frame flag and its clear
//   peak_level / peak_clr          peak magnitude and restart (PEAK_METER_EN)
module audio_receiver (
   input  logic        clk,
   input  logic        rst,
   input  logic        adc_sdout,
   output logic        adc_mclk,
   output logic        adc_lrck,
   output logic        adc_sck,
   output logic [15:0] sample_left,
   output logic [15:0] sample_right,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        overrun,
   input  logic        overrun_clr,
   output logic [15:0] peak_level,
   input  logic        peak_clr
);

   localparam int unsigned CNT_W    = 9;
   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned FRAME_W  = 2 * SAMPLE_W;
   localparam int unsigned SHIFT_W  = FRAME_W - 1;
   localparam logic [3:0]  SAMPLE_PHASE = 4'd9;

   logic [CNT_W-1:0]    r_cnt;
   logic                r_sync1;
   logic                r_sync2;
   logic [SHIFT_W-1:0]  r_shift;
   logic                r_primed;
   logic [SAMPLE_W-1:0] r_left;
   logic [SAMPLE_W-1:0] r_right;
   logic                r_valid;
   logic                r_overrun;

   logic                w_sample;
   logic                w_done;
   logic [FRAME_W-1:0]  w_frame;
   logic                w_load;
   logic                w_drop;
   logic                w_valid_nxt;

   assign adc_mclk     = r_cnt[1];
   assign adc_lrck     = r_cnt[8];
   assign adc_sck      = 1'b1;
   assign sample_left  = r_left;
   assign sample_right = r_right;
   assign out_valid    = r_valid;
   assign overrun      = r_overrun;

   // Slot sampling strobe; slot 0 carries the last bit of the frame.
   always_comb begin
      w_sample    = (r_cnt[3:0] == SAMPLE_PHASE);
      w_done      = w_sample && (r_cnt[8:4] == 5'd0);
      // 31 stored bits plus the bit arriving now form {left, right}.
      w_frame     = {r_shift, r_sync2};
      w_load      = w_done && r_primed && (!r_valid || out_ready);
      w_drop      = w_done && r_primed && r_valid && !out_ready;
      w_valid_nxt = w_load || (r_valid && !out_ready);
   end

   // Counter, synchronizer and deserializer (independent of the handshake).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt    <= '0;
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_shift  <= '0;
         r_primed <= 1'b0;
      end else begin
         r_cnt   <= r_cnt + CNT_W'(1);
         r_sync1 <= adc_sdout;
         r_sync2 <= r_sync1;
         if (w_sample) begin
            r_shift <= w_frame[SHIFT_W-1:0];
         end
         // The first completion after reset only marks the start of whole frames.
         if (w_done) begin
            r_primed <= 1'b1;
         end
      end
   end

   // Output pair, handshake and overrun flag; a set event beats the clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_left    <= '0;
         r_right   <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_load) begin
            r_left  <= w_frame[FRAME_W-1:SAMPLE_W];
            r_right <= w_frame[SAMPLE_W-1:0];
         end
         r_valid   <= w_valid_nxt;
         r_overrun <= w_drop || (r_overrun && !overrun_clr);
      end
   end

`ifdef PEAK_METER_EN
   logic [SAMPLE_W-1:0] r_peak;
   logic [SAMPLE_W-1:0] w_abs_l;
   logic [SAMPLE_W-1:0] w_abs_r;
   logic [SAMPLE_W-1:0] w_peak_base;
   logic [SAMPLE_W-1:0] w_peak_new;

   // Saturating magnitude: -32768 maps to 32767.
   function automatic logic [SAMPLE_W-1:0] f_abs(input logic [SAMPLE_W-1:0] x);
      logic [SAMPLE_W-1:0] neg;
      neg = SAMPLE_W'(~x + SAMPLE_W'(1));
      if (!x[SAMPLE_W-1]) begin
         return x;
      end else if (x == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
         return {1'b0, {(SAMPLE_W-1){1'b1}}};
      end else begin
         return neg;
      end
   endfunction

   // A clear in the same cycle as a load restarts from the new pair alone.
   always_comb begin
      w_abs_l     = f_abs(w_frame[FRAME_W-1:SAMPLE_W]);
      w_abs_r     = f_abs(w_frame[SAMPLE_W-1:0]);
      w_peak_base = peak_clr ? '0 : r_peak;
      w_peak_new  = w_peak_base;
      if (w_abs_l > w_peak_new) begin
         w_peak_new = w_abs_l;
      end
      if (w_abs_r > w_peak_new) begin
         w_peak_new = w_abs_r;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_peak <= '0;
      end else if (w_load) begin
         r_peak <= w_peak_new;
      end else if (peak_clr) begin
         r_peak <= '0;
      end
   end

   assign peak_level = r_peak;
`else
   logic w_unused_peak_clr;
   assign w_unused_peak_clr = peak_clr;
   assign peak_level        = '0;
`endif

endmodule

// File: tb/tb_audio_receiver.sv
// tb_audio_receiver: drives serialized frames lap by lap (one lap = 512 clk =
// one counter period) and checks handshake, overrun, peak and reset behaviour.
// Accepted pairs are checked against a scoreboard queue filled when frames
// expected to be delivered are serialized.
module tb_audio_receiver;

`ifdef PEAK_METER_EN
   localparam bit PEAK_EN = 1'b1;
`else
   localparam bit PEAK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        adc_sdout;
   logic        adc_mclk;
   logic        adc_lrck;
   logic        adc_sck;
   logic [15:0] sample_left;
   logic [15:0] sample_right;
   logic        out_valid;
   logic        out_ready;
   logic        overrun;
   logic        overrun_clr;
   logic [15:0] peak_level;
   logic        peak_clr;

   always #5 clk = ~clk;

   audio_receiver dut (
      .clk         (clk),
      .rst         (rst),
      .adc_sdout   (adc_sdout),
      .adc_mclk    (adc_mclk),
      .adc_lrck    (adc_lrck),
      .adc_sck     (adc_sck),
      .sample_left (sample_left),
      .sample_right(sample_right),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .overrun     (overrun),
      .overrun_clr (overrun_clr),
      .peak_level  (peak_level),
      .peak_clr    (peak_clr)
   );

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] sb_q[$];
   logic [15:0] prev_r = 16'h0;

   // Per-lap options and expectations.
   bit          g_release, g_pulse9, g_oclr9, g_oclr20, g_pclr9, g_pclr20, g_rdy;
   int          g_rst_at;
   logic        e_v9, e_v10, e_ovr10, e_ovr30;
   logic [15:0] e_l10, e_r10, e_pk10, e_pk30;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] pk(input logic [15:0] x);
      return PEAK_EN ? x : 16'h0;
   endfunction

   function automatic logic slot_bit(input int c, input logic [15:0] l, input logic [15:0] r);
      int s;
      s = c / 16;
      if (s == 0)       return prev_r[0];
      else if (s <= 16) return l[16 - s];
      else              return r[32 - s];
   endfunction

   task automatic set_exp(input logic v9, input logic v10, input logic [15:0] l10,
                          input logic [15:0] r10, input logic ovr10, input logic ovr30,
                          input logic [15:0] pk10, input logic [15:0] pk30);
      e_v9 = v9; e_v10 = v10; e_l10 = l10; e_r10 = r10;
      e_ovr10 = ovr10; e_ovr30 = ovr30; e_pk10 = pk(pk10); e_pk30 = pk(pk30);
   endtask

   task automatic clear_opts();
      g_release = 0; g_pulse9 = 0; g_oclr9 = 0; g_oclr20 = 0;
      g_pclr9 = 0; g_pclr20 = 0; g_rst_at = -1;
   endtask

   // Consumer side: a pair is taken at the edge following valid && ready.
   always @(negedge clk) begin
      logic [31:0] e;
      #2;
      if (rst && out_valid && out_ready) begin
         chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_left", 32'(sample_left), 32'(e[31:16]));
            chk("sb_right", 32'(sample_right), 32'(e[15:0]));
         end
      end
   end

   // One counter period; iteration c runs while the DUT counter equals c.
   task automatic run_lap(input logic [15:0] l, input logic [15:0] r, input bit push);
      if (push) sb_q.push_back({l, r});
      for (int c = 0; c < 512; c++) begin
         @(negedge clk);
         if (c == 2)   chk("mclk_c2", 32'(adc_mclk), 32'd1);
         if (c == 300) begin
            chk("lrck_c300", 32'(adc_lrck), 32'd1);
            chk("sck_c300", 32'(adc_sck), 32'd1);
         end
         if (c == 9)   chk("valid_c9", 32'(out_valid), 32'(e_v9));
         if (c == 10) begin
            chk("valid_c10", 32'(out_valid), 32'(e_v10));
            chk("left_c10", 32'(sample_left), 32'(e_l10));
            chk("right_c10", 32'(sample_right), 32'(e_r10));
            chk("ovr_c10", 32'(overrun), 32'(e_ovr10));
            chk("peak_c10", 32'(peak_level), 32'(e_pk10));
         end
         if (c == 30) begin
            chk("ovr_c30", 32'(overrun), 32'(e_ovr30));
            chk("peak_c30", 32'(peak_level), 32'(e_pk30));
         end
         #1;
         adc_sdout = slot_bit(c, l, r);
         if (c == 0 && g_release) rst = 1'b1;
         if (c == 9) begin
            if (g_pulse9) out_ready   = 1'b1;
            if (g_oclr9)  overrun_clr = 1'b1;
            if (g_pclr9)  peak_clr    = 1'b1;
         end
         if (c == 10) begin
            if (g_pulse9) out_ready = 1'b0;
            overrun_clr = 1'b0;
            peak_clr    = 1'b0;
         end
         if (c == 20) begin
            out_ready = g_rdy;
            if (g_oclr20) overrun_clr = 1'b1;
            if (g_pclr20) peak_clr    = 1'b1;
         end
         if (c == 21) begin
            overrun_clr = 1'b0;
            peak_clr    = 1'b0;
         end
         if (c == g_rst_at) begin
            rst = 1'b0;
            #1;
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_left", 32'(sample_left), 32'd0);
            chk("rst_right", 32'(sample_right), 32'd0);
            chk("rst_ovr", 32'(overrun), 32'd0);
            chk("rst_peak", 32'(peak_level), 32'd0);
            chk("rst_lrck", 32'(adc_lrck), 32'd0);
            chk("rst_mclk", 32'(adc_mclk), 32'd0);
            return;
         end
      end
      prev_r = r;
   endtask

   initial begin
      rst = 1'b1; adc_sdout = 1'b0; out_ready = 1'b0;
      overrun_clr = 1'b0; peak_clr = 1'b0; g_rdy = 1'b1;
      clear_opts();
      #3 rst = 1'b0;
      @(negedge clk);
      chk("init_valid", 32'(out_valid), 32'd0);
      chk("init_left", 32'(sample_left), 32'd0);
      chk("init_right", 32'(sample_right), 32'd0);
      chk("init_ovr", 32'(overrun), 32'd0);
      chk("init_peak", 32'(peak_level), 32'd0);
      chk("init_mclk", 32'(adc_mclk), 32'd0);
      chk("init_lrck", 32'(adc_lrck), 32'd0);
      chk("init_sck", 32'(adc_sck), 32'd1);

      // Lap 0: first completion after reset is discarded.
      clear_opts(); g_release = 1; g_rdy = 1;
      set_exp(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
      run_lap(16'h1234, 16'hABCD, 1);
      // Lap 1: pair 0 appears at cnt==10; consumer then stalls.
      clear_opts(); g_rdy = 0;
      set_exp(0, 1, 16'h1234, 16'hABCD, 0, 0, 16'h5433, 16'h5433);
      run_lap(16'h0001, 16'h0011, 1);
      // Lap 2: pair 1 loaded while stalled.
      clear_opts(); g_rdy = 0;
      set_exp(0, 1, 16'h0001, 16'h0011, 0, 0, 16'h5433, 16'h5433);
      run_lap(16'h0002, 16'h0022, 0);
      // Lap 3: pair 2 dropped, overrun set.
      clear_opts(); g_rdy = 0;
      set_exp(1, 1, 16'h0001, 16'h0011, 1, 1, 16'h5433, 16'h5433);
      run_lap(16'h0003, 16'h0033, 0);
      // Lap 4: pair 3 dropped with a clear in the same cycle; later clear.
      clear_opts(); g_rdy = 0; g_oclr9 = 1; g_oclr20 = 1;
      set_exp(1, 1, 16'h0001, 16'h0011, 1, 0, 16'h5433, 16'h5433);
      run_lap(16'h4444, 16'h5555, 1);
      // Lap 5: ready only at the completion edge: accept and load together.
      clear_opts(); g_pulse9 = 1; g_rdy = 1;
      set_exp(1, 1, 16'h4444, 16'h5555, 0, 0, 16'h5555, 16'h5555);
      run_lap(16'h8000, 16'h0100, 1);
      // Lap 6: saturating magnitude of -32768.
      clear_opts(); g_rdy = 1;
      set_exp(0, 1, 16'h8000, 16'h0100, 0, 0, 16'h7FFF, 16'h7FFF);
      run_lap(16'h0200, 16'hFF00, 1);
      // Lap 7: peak holds, then peak_clr alone.
      clear_opts(); g_rdy = 1; g_pclr20 = 1;
      set_exp(0, 1, 16'h0200, 16'hFF00, 0, 0, 16'h7FFF, 16'h0000);
      run_lap(16'h0010, 16'hFFF0, 1);
      // Lap 8: fresh measurement after clear.
      clear_opts(); g_rdy = 1;
      set_exp(0, 1, 16'h0010, 16'hFFF0, 0, 0, 16'h0010, 16'h0010);
      run_lap(16'hFFFE, 16'h0003, 1);
      // Lap 9: peak_clr with a load, then reset at cnt==200.
      clear_opts(); g_rdy = 1; g_pclr9 = 1; g_rst_at = 200;
      set_exp(0, 1, 16'hFFFE, 16'h0003, 0, 0, 16'h0003, 16'h0003);
      run_lap(16'h7777, 16'h1111, 0);
      // Lap 10: partial frame after reset is discarded again.
      clear_opts(); g_release = 1; g_rdy = 1;
      set_exp(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
      run_lap(16'h0F0F, 16'hF0F0, 1);
      // Lap 11: normal delivery resumes.
      clear_opts(); g_rdy = 1;
      set_exp(0, 1, 16'h0F0F, 16'hF0F0, 0, 0, 16'h0F10, 16'h0F10);
      run_lap(16'h0000, 16'h0000, 0);

      repeat (4) @(negedge clk);
      chk("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
